// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer: state encoding, row geometry
// and the row-advance helper.
package scan_pkg;

   localparam int ROWS  = 4;
   localparam int SEL_W = 2;

   // The ST_ prefix keeps the BLANK state apart from the BLANK gap parameter.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   localparam logic [SEL_W-1:0] LAST_ROW = SEL_W'(ROWS - 1);

   // ROWS is a power of two, so the natural wrap of SEL_W bits gives 3 -> 0.
   function automatic logic [SEL_W-1:0] next_row(input logic [SEL_W-1:0] row);
      return row + SEL_W'(1);
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter that times the dwell and blank intervals.
// It saturates at zero and reports both the current and the upcoming zero
// state, so the owner can register pulses that line up with the last cycle.
module scan_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero,
   output logic             o_zero_nxt
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;

   // Next count: a load wins over a decrement; the counter never wraps below zero.
   always_comb begin
      w_count_nxt = r_count;
      if (i_load) begin
         w_count_nxt = i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign o_zero     = (r_count == '0);
   assign o_zero_nxt = (w_count_nxt == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Timed select generator for the 2-to-4 enable decoder. Walks rows 0..3,
// holding en high for DWELL cycles per row with BLANK low cycles between
// rows, as a single pass or a continuous scan with start/stop control.
// Every output is a flop loaded from the next-state logic, so each output
// lines up with the state it describes rather than trailing it by a cycle.
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int DWELL = 4,
   parameter int BLANK = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             mode_single,
   output logic             en,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             row_done,
   output logic             pass_done
);

   // Counter reload values; DWELL >= 1 and BLANK <= 2^CNT_W keep both in range.
   localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] BLANK_LD = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] w_sel_nxt;
   logic             r_mode_single;
   logic             w_mode_nxt;
   logic             r_stop_pend;
   logic             w_stop_pend_nxt;

   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_dec;
   logic             w_zero;
   logic             w_zero_nxt;
   logic             w_last_nxt;

   logic             r_en;
   logic             r_busy;
   logic             r_row_done;
   logic             r_pass_done;

   scan_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_zero     (w_zero),
      .o_zero_nxt (w_zero_nxt)
   );

   // Next-state, next-row and timer control for the IDLE/DRIVE/BLANK sequence.
   always_comb begin
      // NOTE: every signal driven here gets a default first; a path that
      // leaves one unassigned would make synthesis infer a latch.
      w_state_nxt     = r_state;
      w_sel_nxt       = r_sel;
      w_mode_nxt      = r_mode_single;
      w_stop_pend_nxt = r_stop_pend;
      w_load          = 1'b0;
      w_load_val      = DWELL_LD;
      w_dec           = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_stop_pend_nxt = 1'b0;
            // A simultaneous stop cancels the start; a lone stop does nothing.
            if (start && !stop) begin
               w_state_nxt = ST_DRIVE;
               w_sel_nxt   = '0;
               w_load      = 1'b1;
               w_mode_nxt  = mode_single;
            end
         end

         ST_DRIVE: begin
            // A stop during the dwell is remembered; the row always completes.
            if (stop) begin
               w_stop_pend_nxt = 1'b1;
            end
            if (w_zero) begin
               if (r_stop_pend || stop || (r_mode_single && (r_sel == LAST_ROW))) begin
                  w_state_nxt     = ST_IDLE;
                  w_sel_nxt       = '0;
                  w_stop_pend_nxt = 1'b0;
               end else if (BLANK > 0) begin
                  w_state_nxt = ST_BLANK;
                  w_load      = 1'b1;
                  w_load_val  = BLANK_LD;
               end else begin
                  // No gap: advance the row and keep en high without a break.
                  w_sel_nxt = next_row(r_sel);
                  w_load    = 1'b1;
               end
            end else begin
               w_dec = 1'b1;
            end
         end

         ST_BLANK: begin
            // The row is already complete, so a stop here ends the scan at once.
            if (stop) begin
               w_state_nxt = ST_IDLE;
               w_sel_nxt   = '0;
            end else if (w_zero) begin
               w_state_nxt = ST_DRIVE;
               w_sel_nxt   = next_row(r_sel);
               w_load      = 1'b1;
            end else begin
               w_dec = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_sel_nxt   = '0;
         end
      endcase
   end

   // The coming cycle is the last cycle of a row when it is a DRIVE cycle with the counter at zero.
   assign w_last_nxt = (w_state_nxt == ST_DRIVE) && w_zero_nxt;

   // State, row index, captured mode and pending-stop flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_sel         <= '0;
         r_mode_single <= 1'b0;
         r_stop_pend   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples the values from before this clock edge.
         r_state       <= w_state_nxt;
         r_sel         <= w_sel_nxt;
         r_mode_single <= w_mode_nxt;
         r_stop_pend   <= w_stop_pend_nxt;
      end
   end

   // Registered decoder enable, busy flag and end-of-row/end-of-pass pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en        <= 1'b0;
         r_busy      <= 1'b0;
         r_row_done  <= 1'b0;
         r_pass_done <= 1'b0;
      end else begin
         r_en        <= (w_state_nxt == ST_DRIVE);
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_row_done  <= w_last_nxt;
         r_pass_done <= w_last_nxt && (w_sel_nxt == LAST_ROW);
      end
   end

   assign en        = r_en;
   assign sel       = r_sel;
   assign busy      = r_busy;
   assign row_done  = r_row_done;
   assign pass_done = r_pass_done;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer. Two instances run side by side: instance 0 with
// DWELL=4/BLANK=1 and instance 1 with DWELL=2/BLANK=0. The reference model
// tracks each scan as a cycle index t since the first en cycle and derives
// row, phase and outputs from t with plain arithmetic. The downstream 2-to-4
// decoder is modelled as y = en ? (1 << {sel[1], sel[0]}) : 0.
// Output vectors are packed as {en, sel[1:0], busy, row_done, pass_done}.
module tb_scan_sequencer;

   localparam int DW0 = 4;
   localparam int BL0 = 1;
   localparam int DW1 = 2;
   localparam int BL1 = 0;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic [1:0] start_v = '0;
   logic [1:0] stop_v  = '0;
   logic [1:0] mode_v  = '0;
   logic [1:0] en_w;
   logic [1:0] busy_w;
   logic [1:0] rd_w;
   logic [1:0] pd_w;
   logic [1:0] sel_w [2];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, one entry per instance.
   bit m_active [2];
   int m_t      [2];
   bit m_pend   [2];
   bit m_single [2];

   always #5 clk = ~clk;

   scan_sequencer #(.DWELL(DW0), .BLANK(BL0), .CNT_W(8)) u_dut0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_v[0]),
      .stop        (stop_v[0]),
      .mode_single (mode_v[0]),
      .en          (en_w[0]),
      .sel         (sel_w[0]),
      .busy        (busy_w[0]),
      .row_done    (rd_w[0]),
      .pass_done   (pd_w[0])
   );

   scan_sequencer #(.DWELL(DW1), .BLANK(BL1), .CNT_W(8)) u_dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_v[1]),
      .stop        (stop_v[1]),
      .mode_single (mode_v[1]),
      .en          (en_w[1]),
      .sel         (sel_w[1]),
      .busy        (busy_w[1]),
      .row_done    (rd_w[1]),
      .pass_done   (pd_w[1])
   );

   function automatic int dw(input int i);
      return (i == 0) ? DW0 : DW1;
   endfunction

   function automatic int per(input int i);
      return (i == 0) ? (DW0 + BL0) : (DW1 + BL1);
   endfunction

   function automatic int ph_of(input int i);
      return m_t[i] % per(i);
   endfunction

   function automatic int row_of(input int i);
      return (m_t[i] / per(i)) % 4;
   endfunction

   function automatic logic [5:0] exp_vec(input int i);
      logic [1:0] row2;
      if (!m_active[i]) return 6'd0;
      row2 = 2'(row_of(i));
      return {ph_of(i) < dw(i), row2, 1'b1, ph_of(i) == dw(i) - 1,
              (ph_of(i) == dw(i) - 1) && (row_of(i) == 3)};
   endfunction

   function automatic logic [5:0] obs_vec(input int i);
      return {en_w[i], sel_w[i], busy_w[i], rd_w[i], pd_w[i]};
   endfunction

   function automatic logic [3:0] dec_y(input int i);
      logic [1:0] idx;
      idx = {sel_w[i][1], sel_w[i][0]};
      return en_w[i] ? (4'b0001 << idx) : 4'b0000;
   endfunction

   // Reference model: t advances one per busy cycle; the scan ends after the
   // last dwell cycle of a row (stop or end of a single pass) or immediately
   // when stopped during a gap.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_active[i] <= 1'b0;
            m_t[i]      <= 0;
            m_pend[i]   <= 1'b0;
            m_single[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!m_active[i]) begin
               if (start_v[i] && !stop_v[i]) begin
                  m_active[i] <= 1'b1;
                  m_t[i]      <= 0;
                  m_single[i] <= mode_v[i];
                  m_pend[i]   <= 1'b0;
               end
            end else if (ph_of(i) < dw(i)) begin
               if ((ph_of(i) == dw(i) - 1) &&
                   (m_pend[i] || stop_v[i] || (m_single[i] && row_of(i) == 3))) begin
                  m_active[i] <= 1'b0;
                  m_pend[i]   <= 1'b0;
               end else begin
                  m_t[i] <= (m_t[i] + 1) % (4 * per(i));
                  if (stop_v[i]) m_pend[i] <= 1'b1;
               end
            end else begin
               if (stop_v[i]) m_active[i] <= 1'b0;
               else           m_t[i] <= (m_t[i] + 1) % (4 * per(i));
            end
         end
      end
   end

   // Apply inputs for one cycle, let the edge sample them, then observe at the falling edge.
   task automatic step(input logic [1:0] st, input logic [1:0] sp, input logic [1:0] md);
      start_v = st;
      stop_v  = sp;
      mode_v  = md;
      @(posedge clk);
      #1;
      start_v = '0;
      stop_v  = '0;
      @(negedge clk);
   endtask

   // Stop instance i and wait, bounded, for it to go idle.
   task automatic drain(input int i);
      logic [1:0] sp;
      bit         done;
      done = 1'b0;
      sp   = 2'b01 << i;
      step(2'b00, sp, mode_v);
      for (int k = 0; k < 40 && !done; k++) begin
         if (!busy_w[i]) done = 1'b1;
         else            step(2'b00, 2'b00, mode_v);
      end
      if (!done) begin
         n_fail++;
         $display("FAIL drain dut=%0d busy still high after 40 cycles, expected 0", i);
      end
      n_checks++;
   endtask

   task automatic test_reset;
      #12;
      for (int i = 0; i < 2; i++) begin
         if (obs_vec(i) !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_state dut=%0d got=%b exp=000000", i, obs_vec(i));
         end
         n_checks++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step(2'b00, 2'b00, 2'b00);
         for (int i = 0; i < 2; i++) begin
            if (obs_vec(i) !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL reset_idle dut=%0d got=%b exp=%b", i, obs_vec(i), exp_vec(i));
            end
            n_checks++;
         end
      end
   endtask

   task automatic test_single_pass;
      logic [3:0] ey;
      step(2'b01, 2'b00, 2'b01);
      for (int c = 1; c <= 21; c++) begin
         ey = 4'b0000;
         if (c <= 19 && ((c - 1) % 5) < 4) ey = 4'b0001 << ((c - 1) / 5);
         if (dec_y(0) !== ey) begin
            n_fail++;
            $display("FAIL single_y cyc=%0d got=%b exp=%b", c, dec_y(0), ey);
         end
         n_checks++;
         if (pd_w[0] !== (c == 19)) begin
            n_fail++;
            $display("FAIL single_pass_done cyc=%0d got=%b exp=%b", c, pd_w[0], c == 19);
         end
         n_checks++;
         if (c == 20 && {busy_w[0], sel_w[0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_end cyc=%0d busy_sel got=%b exp=000", c, {busy_w[0], sel_w[0]});
         end
         if (c == 20) n_checks++;
         if (obs_vec(0) !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL single_model cyc=%0d got=%b exp=%b", c, obs_vec(0), exp_vec(0));
         end
         n_checks++;
         step(2'b00, 2'b00, 2'b01);
      end
   endtask

   task automatic test_continuous;
      int n_rd;
      int n_pd;
      n_rd = 0;
      n_pd = 0;
      step(2'b01, 2'b00, 2'b00);
      for (int c = 1; c <= 45; c++) begin
         if (rd_w[0]) n_rd++;
         if (pd_w[0]) n_pd++;
         if (pd_w[0] && c != 19 && c != 39) begin
            n_fail++;
            $display("FAIL cont_pass_done unexpected pulse cyc=%0d, expected only 19 and 39", c);
         end
         if (pd_w[0]) n_checks++;
         if (c == 20 && {en_w[0], sel_w[0]} !== 3'b011) begin
            n_fail++;
            $display("FAIL cont_blank_row3 got=%b exp=011", {en_w[0], sel_w[0]});
         end
         if (c == 21 && {en_w[0], sel_w[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL cont_wrap got=%b exp=100", {en_w[0], sel_w[0]});
         end
         if (c == 20 || c == 21) n_checks++;
         if (obs_vec(0) !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL cont_model cyc=%0d got=%b exp=%b", c, obs_vec(0), exp_vec(0));
         end
         n_checks++;
         step(2'b00, 2'b00, 2'b00);
      end
      if (n_rd !== 9) begin
         n_fail++;
         $display("FAIL cont_row_done_count got=%0d exp=9", n_rd);
      end
      n_checks++;
      if (n_pd !== 2) begin
         n_fail++;
         $display("FAIL cont_pass_done_count got=%0d exp=2", n_pd);
      end
      n_checks++;
      drain(0);
   endtask

   task automatic test_stop_drive;
      for (int c = 0; c <= 16; c++) begin
         step((c == 0) ? 2'b01 : 2'b00, (c == 12) ? 2'b01 : 2'b00, 2'b00);
         if ((c + 1) == 14 && {en_w[0], busy_w[0], sel_w[0]} !== 4'b1110) begin
            n_fail++;
            $display("FAIL stop_drive_last got=%b exp=1110", {en_w[0], busy_w[0], sel_w[0]});
         end
         if ((c + 1) == 15 && {en_w[0], busy_w[0], sel_w[0]} !== 4'b0000) begin
            n_fail++;
            $display("FAIL stop_drive_idle got=%b exp=0000", {en_w[0], busy_w[0], sel_w[0]});
         end
         if ((c + 1) == 14 || (c + 1) == 15) n_checks++;
         if (obs_vec(0) !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL stop_drive_model cyc=%0d got=%b exp=%b", c + 1, obs_vec(0), exp_vec(0));
         end
         n_checks++;
      end
   endtask

   task automatic test_stop_blank;
      for (int c = 0; c <= 7; c++) begin
         step((c == 0) ? 2'b01 : 2'b00, (c == 5) ? 2'b01 : 2'b00, 2'b00);
         if ((c + 1) == 5 && {en_w[0], busy_w[0], sel_w[0]} !== 4'b0100) begin
            n_fail++;
            $display("FAIL stop_blank_gap got=%b exp=0100", {en_w[0], busy_w[0], sel_w[0]});
         end
         if ((c + 1) == 6 && {en_w[0], busy_w[0], sel_w[0]} !== 4'b0000) begin
            n_fail++;
            $display("FAIL stop_blank_idle got=%b exp=0000", {en_w[0], busy_w[0], sel_w[0]});
         end
         if ((c + 1) == 5 || (c + 1) == 6) n_checks++;
         if (obs_vec(0) !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL stop_blank_model cyc=%0d got=%b exp=%b", c + 1, obs_vec(0), exp_vec(0));
         end
         n_checks++;
      end
   endtask

   task automatic test_async_reset;
      step(2'b01, 2'b00, 2'b00);
      for (int c = 0; c < 6; c++) step(2'b00, 2'b00, 2'b00);
      if (obs_vec(0) !== exp_vec(0)) begin
         n_fail++;
         $display("FAIL areset_pre got=%b exp=%b", obs_vec(0), exp_vec(0));
      end
      n_checks++;
      #1;
      rst_n = 1'b0;
      #1;
      if ({en_w[0], busy_w[0], sel_w[0]} !== 4'b0000) begin
         n_fail++;
         $display("FAIL areset_async got=%b exp=0000", {en_w[0], busy_w[0], sel_w[0]});
      end
      n_checks++;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      step(2'b01, 2'b00, 2'b00);
      if ({en_w[0], busy_w[0], sel_w[0]} !== 4'b1100) begin
         n_fail++;
         $display("FAIL areset_restart got=%b exp=1100", {en_w[0], busy_w[0], sel_w[0]});
      end
      n_checks++;
      drain(0);
   endtask

   task automatic test_blank_zero;
      logic [5:0] ev;
      for (int c = 0; c <= 9; c++) begin
         step((c == 0) ? 2'b10 : 2'b00, 2'b00, 2'b10);
         ev = 6'd0;
         if ((c + 1) <= 8) ev = {1'b1, 2'(c / 2), 1'b1, ((c + 1) % 2) == 0, (c + 1) == 8};
         if (obs_vec(1) !== ev) begin
            n_fail++;
            $display("FAIL blank_zero cyc=%0d got=%b exp=%b", c + 1, obs_vec(1), ev);
         end
         n_checks++;
         if (obs_vec(1) !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL blank_zero_model cyc=%0d got=%b exp=%b", c + 1, obs_vec(1), exp_vec(1));
         end
         n_checks++;
      end
   endtask

   task automatic test_start_ignored;
      for (int c = 0; c <= 21; c++) begin
         step((c == 0 || c == 3 || c == 7) ? 2'b01 : 2'b00, 2'b00, 2'b01);
         if (pd_w[0] !== ((c + 1) == 19)) begin
            n_fail++;
            $display("FAIL ignore_pass_done cyc=%0d got=%b exp=%b", c + 1, pd_w[0], (c + 1) == 19);
         end
         n_checks++;
         if (obs_vec(0) !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL ignore_model cyc=%0d got=%b exp=%b", c + 1, obs_vec(0), exp_vec(0));
         end
         n_checks++;
      end
      step(2'b01, 2'b01, 2'b01);
      for (int c = 0; c < 2; c++) begin
         if (busy_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_idle cyc=%0d busy got=%b exp=0", c, busy_w[0]);
         end
         n_checks++;
         step(2'b00, 2'b00, 2'b01);
      end
   endtask

   task automatic test_random;
      logic [1:0] st;
      logic [1:0] sp;
      logic [1:0] md;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 2; i++) begin
            st[i] = ($urandom_range(0, 7) == 0);
            sp[i] = ($urandom_range(0, 29) == 0);
            md[i] = ($urandom_range(0, 1) == 0);
         end
         step(st, sp, md);
         for (int i = 0; i < 2; i++) begin
            if (obs_vec(i) !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL random dut=%0d cyc=%0d got=%b exp=%b", i, c, obs_vec(i), exp_vec(i));
            end
            n_checks++;
         end
      end
      drain(0);
      drain(1);
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_continuous();
      test_stop_drive();
      test_stop_blank();
      test_async_reset();
      test_blank_zero();
      test_start_ignored();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
